// File: rtl/bp_pkg.sv
// bp_pkg: shared entry layout and default widths for the branch checkpoint queue.
package bp_pkg;
  localparam int DEF_PHT_DEPTH = 7;
  localparam int DEF_GHR_WIDTH = 4;
  typedef struct packed {
    logic                     pred;
    logic [DEF_PHT_DEPTH-1:0] index;
    logic [DEF_GHR_WIDTH-1:0] ghr;
    logic [31:0]              alt_pc;
  } bpq_entry_t;
endpackage

// File: rtl/bpq_sat_counter.sv
// bpq_sat_counter: 32-bit event counter that sticks at all-ones; active-low sync reset.
module bpq_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] count_o
);
  logic [31:0] count_q, count_d;
  always_comb count_d = (inc_i && count_q != '1) ? count_q + 32'd1 : count_q;
  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
endmodule

// File: rtl/bp_checkpoint_queue.sv
// bp_checkpoint_queue: in-order queue of in-flight branch predictions driving PHT update and mispredict recovery.
// Define BPQ_STATS_EN to add saturating resolve/mispredict counters (stat_resolved, stat_mispredict).
module bp_checkpoint_queue
  import bp_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PHT_DEPTH = DEF_PHT_DEPTH,
  parameter int GHR_WIDTH = DEF_GHR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic                   alloc_pred,
  input  logic [PHT_DEPTH-1:0]   alloc_index,
  input  logic [GHR_WIDTH-1:0]   alloc_ghr,
  input  logic [31:0]            alloc_alt_pc,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic                   flush_all,
  output logic                   upd_valid,
  output logic [PHT_DEPTH-1:0]   upd_index,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [31:0]            recover_pc,
  output logic [GHR_WIDTH-1:0]   recover_ghr,
  output logic [$clog2(DEPTH):0] count,
`ifdef BPQ_STATS_EN
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispredict,
`endif
  output logic                   resolve_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic                 pred;
    logic [PHT_DEPTH-1:0] index;
    logic [GHR_WIDTH-1:0] ghr;
    logic [31:0]          alt_pc;
  } entry_t;
  entry_t               mem_q [DEPTH];
  entry_t               head_e, alloc_e;
  logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [PHT_DEPTH-1:0] upd_index_q, upd_index_d;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          recover_pc_q, recover_pc_d;
  logic [GHR_WIDTH-1:0] recover_ghr_q, recover_ghr_d;
  logic                 resolve_err_q, resolve_err_d;
  logic                 full, empty, do_alloc, do_res, mis, clear;
  always_comb begin
    full     = count_q == CW'(DEPTH);
    empty    = count_q == '0;
    do_alloc = alloc_valid && !full && !flush_all;
    do_res   = resolve_valid && !empty && !flush_all;
    head_e   = mem_q[head_q];
    alloc_e  = '{pred: alloc_pred, index: alloc_index, ghr: alloc_ghr, alt_pc: alloc_alt_pc};
    mis      = do_res && (head_e.pred != resolve_taken);
    // A mispredict squashes every younger (wrong-path) entry, including a same-cycle alloc.
    clear    = flush_all || mis;
    head_d   = clear ? tail_q : head_q + AW'(do_res);
    tail_d   = clear ? tail_q : tail_q + AW'(do_alloc);
    count_d  = clear ? '0 : count_q + CW'(do_alloc) - CW'(do_res);
    upd_valid_d   = do_res;
    upd_index_d   = do_res ? head_e.index : upd_index_q;
    upd_taken_d   = do_res ? resolve_taken : upd_taken_q;
    mispredict_d  = mis;
    recover_pc_d  = mis ? head_e.alt_pc : recover_pc_q;
    recover_ghr_d = mis ? {head_e.ghr[GHR_WIDTH-2:0], resolve_taken} : recover_ghr_q;
    resolve_err_d = resolve_err_q || (resolve_valid && empty && !flush_all);
  end
  always_ff @(posedge clk) begin
    if (do_alloc) mem_q[tail_q] <= alloc_e;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      recover_pc_q  <= '0;
      recover_ghr_q <= '0;
      resolve_err_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_index_q   <= upd_index_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      recover_pc_q  <= recover_pc_d;
      recover_ghr_q <= recover_ghr_d;
      resolve_err_q <= resolve_err_d;
    end
  end
  assign alloc_ready = !full;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign recover_pc  = recover_pc_q;
  assign recover_ghr = recover_ghr_q;
  assign count       = count_q;
  assign resolve_err = resolve_err_q;
`ifdef BPQ_STATS_EN
  bpq_sat_counter u_stat_resolved (.clk(clk), .rst(rst), .inc_i(do_res), .count_o(stat_resolved));
  bpq_sat_counter u_stat_mispredict (.clk(clk), .rst(rst), .inc_i(mis), .count_o(stat_mispredict));
`endif
endmodule

// File: tb/tb_bp_checkpoint_queue.sv
// tb_bp_checkpoint_queue: directed plus randomized checks of bp_checkpoint_queue against a queue-based model.
module tb_bp_checkpoint_queue;
  typedef struct packed {
    logic       pred;
    logic [6:0] index;
    logic [3:0] ghr;
    logic [31:0] alt;
  } ent_t;
  logic        clk = 0, rst = 0;
  logic        alloc_valid = 0, alloc_pred = 0, resolve_valid = 0, resolve_taken = 0, flush_all = 0;
  logic [6:0]  alloc_index = 0;
  logic [3:0]  alloc_ghr = 0;
  logic [31:0] alloc_alt_pc = 0;
  logic        alloc_ready, upd_valid, upd_taken, mispredict, resolve_err;
  logic [6:0]  upd_index;
  logic [31:0] recover_pc;
  logic [3:0]  recover_ghr;
  logic [2:0]  count;
`ifdef BPQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif
  int total = 0, bad = 0;
  bit chk = 0;
  ent_t mq[$];
  logic m_err, m_uv, m_ut, m_mis;
  logic [6:0] m_ui;
  logic [31:0] m_rpc, m_sres, m_smis;
  logic [3:0] m_rghr;

  bp_checkpoint_queue dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pred(alloc_pred), .alloc_index(alloc_index), .alloc_ghr(alloc_ghr),
    .alloc_alt_pc(alloc_alt_pc), .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .flush_all(flush_all), .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .recover_pc(recover_pc), .recover_ghr(recover_ghr), .count(count),
`ifdef BPQ_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict),
`endif
    .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    ent_t e;
    bit aok;
    if (!rst) begin
      mq.delete();
      {m_err, m_uv, m_ut, m_mis, m_ui, m_rpc, m_rghr, m_sres, m_smis} = '0;
      return;
    end
    m_uv = 0;
    m_mis = 0;
    if (flush_all) begin
      mq.delete();
      return;
    end
    aok = alloc_valid && mq.size() != 4;
    if (resolve_valid && mq.size() == 0) m_err = 1;
    if (resolve_valid && mq.size() > 0) begin
      e = mq.pop_front();
      m_uv = 1;
      m_ui = e.index;
      m_ut = resolve_taken;
      if (m_sres != '1) m_sres++;
      if (e.pred != resolve_taken) begin
        m_mis = 1;
        m_rpc = e.alt;
        m_rghr = {e.ghr[2:0], resolve_taken};
        if (m_smis != '1) m_smis++;
        mq.delete();
        aok = 0;
      end
    end
    if (aok) mq.push_back('{alloc_pred, alloc_index, alloc_ghr, alloc_alt_pc});
  endtask

  task automatic drive(input logic av, input logic ap, input logic [6:0] ai, input logic [3:0] ag,
                       input logic [31:0] apc, input logic rv, input logic rt, input logic fl);
    {alloc_valid, alloc_pred, alloc_index, alloc_ghr, alloc_alt_pc} = {av, ap, ai, ag, apc};
    {resolve_valid, resolve_taken, flush_all} = {rv, rt, fl};
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 7'h0, 4'h0, 32'h0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("count", 32'(count), 32'(mq.size()));
      check("alloc_ready", 32'(alloc_ready), 32'(mq.size() != 4));
      check("upd_valid", 32'(upd_valid), 32'(m_uv));
      check("mispredict", 32'(mispredict), 32'(m_mis));
      check("resolve_err", 32'(resolve_err), 32'(m_err));
      if (m_uv) begin
        check("upd_index", 32'(upd_index), 32'(m_ui));
        check("upd_taken", 32'(upd_taken), 32'(m_ut));
      end
      if (m_mis) begin
        check("recover_pc", recover_pc, m_rpc);
        check("recover_ghr", 32'(recover_ghr), 32'(m_rghr));
      end
`ifdef BPQ_STATS_EN
      check("stat_resolved", stat_resolved, m_sres);
      check("stat_mispredict", stat_mispredict, m_smis);
`endif
    end
  end

  initial begin
    logic av, rv, rt, mis_pick;
    rst = 0;
    idle();
    idle();
    chk = 1;
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(alloc_ready), 1);
    check("rst_err", 32'(resolve_err), 0);
    check("rst_upd_valid", 32'(upd_valid), 0);
    rst = 1;
    for (int i = 0; i < 4; i++) drive(1, 1, 7'(16 + i), 4'(i), 32'(32'h1000 + i), 0, 0, 0);
    check("fill_count", 32'(count), 4);
    check("fill_ready", 32'(alloc_ready), 0);
    drive(1, 1, 7'h14, 4'h0, 32'h0, 0, 0, 0);
    check("drop_count", 32'(count), 4);
    drive(0, 0, 7'h0, 4'h0, 32'h0, 1, 1, 0);
    check("res_upd_valid", 32'(upd_valid), 1);
    check("res_upd_index", 32'(upd_index), 32'h10);
    check("res_upd_taken", 32'(upd_taken), 1);
    check("res_mispredict", 32'(mispredict), 0);
    check("res_count", 32'(count), 3);
    drive(0, 0, 7'h0, 4'h0, 32'h0, 0, 0, 1);
    check("flush_count", 32'(count), 0);
    drive(1, 1, 7'h20, 4'b0110, 32'hBFC0_0100, 0, 0, 0);
    drive(1, 1, 7'h21, 4'h3, 32'h2000, 0, 0, 0);
    drive(1, 1, 7'h22, 4'h0, 32'h0, 1, 0, 0);
    check("mis_pulse", 32'(mispredict), 1);
    check("mis_pc", recover_pc, 32'hBFC0_0100);
    check("mis_ghr", 32'(recover_ghr), 32'b1100);
    check("mis_count", 32'(count), 0);
    check("mis_upd_index", 32'(upd_index), 32'h20);
    check("mis_upd_taken", 32'(upd_taken), 0);
    idle();
    check("mis_deassert", 32'(mispredict), 0);
    drive(1, 0, 7'h40, 4'h1, 32'h3000, 0, 0, 0);
    drive(1, 0, 7'h41, 4'h2, 32'h3004, 0, 0, 0);
    drive(1, 0, 7'h42, 4'h0, 32'h0, 1, 1, 1);
    check("fl_count", 32'(count), 0);
    check("fl_upd_valid", 32'(upd_valid), 0);
    check("fl_mispredict", 32'(mispredict), 0);
    drive(0, 0, 7'h0, 4'h0, 32'h0, 1, 0, 0);
    check("err_set", 32'(resolve_err), 1);
    idle();
    check("err_sticky", 32'(resolve_err), 1);
    rst = 0;
    idle();
    rst = 1;
    check("err_clr", 32'(resolve_err), 0);
    check("err_rst_count", 32'(count), 0);
    check("err_rst_ready", 32'(alloc_ready), 1);
    check("err_rst_pc", recover_pc, 0);
    drive(1, 1, 7'h30, 4'h0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 7'(49 + i), 4'h0, 32'h0, 1, 1, 0);
      check("stream_idx", 32'(upd_index), 32'(48 + i));
      check("stream_count", 32'(count), 1);
    end
`ifdef BPQ_STATS_EN
    check("stat_res10", stat_resolved, 10);
    check("stat_mis0", stat_mispredict, 0);
`endif
    for (int n = 0; n < 800; n++) begin
      rst = $urandom_range(0, 199) != 0;
      av = $urandom_range(0, 9) < 6;
      rv = $urandom_range(0, 9) < 4;
      mis_pick = $urandom_range(0, 7) == 0;
      rt = (mq.size() > 0) ? (mq[0].pred ^ mis_pick) : 1'($urandom_range(0, 1));
      drive(av, 1'($urandom_range(0, 1)), 7'($urandom), 4'($urandom), $urandom, rv, rt,
            $urandom_range(0, 39) == 0);
    end
    rst = 1;
    idle();
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_checkpoint_queue.md
Name: bp_checkpoint_queue

Overview:
- In-order queue of in-flight branch predictions.
- Fetch allocates one entry per predicted branch, holding the prediction, PHT index, GHR snapshot and alternate-path PC.
- The resolution stage retires the oldest entry with the actual outcome. The block then emits the registered PHT update, the misprediction pulse, the recovery PC and the repaired GHR toward the global-history predictor and the PC mux.
- It is the resolve/recovery end of the predictor's predict/update interface.

Parameters:
- DEPTH, 4, number of entries; power of 2, range 2..16.
- PHT_DEPTH, 7, PHT index width.
- GHR_WIDTH, 4, global history width.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- alloc_valid  in  1  fetch has a predicted branch to record.
- alloc_ready  out  1  queue not full.
- alloc_pred  in  1  predicted taken.
- alloc_index  in  PHT_DEPTH  PHT index used for the prediction.
- alloc_ghr  in  GHR_WIDTH  GHR value before this branch was shifted in.
- alloc_alt_pc  in  32  PC of the path not predicted.
- resolve_valid  in  1  oldest branch resolved this cycle.
- resolve_taken  in  1  actual outcome.
- flush_all  in  1  squash every entry (exception/eret).
- upd_valid  out  1  PHT update strobe.
- upd_index  out  PHT_DEPTH  PHT entry to update.
- upd_taken  out  1  outcome to train with.
- mispredict  out  1  one-cycle recovery pulse.
- recover_pc  out  32  redirect PC; valid while mispredict=1.
- recover_ghr  out  GHR_WIDTH  repaired GHR, equal to {ghr[GHR_WIDTH-2:0], resolve_taken}.
- count  out  $clog2(DEPTH)+1  occupancy.
- resolve_err  out  1  sticky: resolve_valid arrived while the queue was empty.

Behaviour:
- Reset (rst=0 at posedge): head=tail=count=0. upd_valid, mispredict, resolve_err, upd_index, upd_taken, recover_pc and recover_ghr are all 0. alloc_ready=1 after reset.
- alloc_ready = (count != DEPTH), combinational from registered count; no same-cycle bypass of a freeing resolve.
- Allocation: alloc_valid && alloc_ready writes the entry at tail, tail+1 (mod DEPTH), count+1. alloc_valid while full is dropped; no state change.
- Resolution (resolve_valid, count>0): read the head entry and pop it (head+1 mod DEPTH).
  - Next cycle: upd_valid=1, upd_index=entry.index, upd_taken=resolve_taken. Latency is 1 cycle, all outputs registered.
  - If entry.pred != resolve_taken: next cycle mispredict=1, recover_pc=entry.alt_pc, recover_ghr={entry.ghr[GHR_WIDTH-2:0], resolve_taken}.
  - On a mispredict, all remaining entries are younger wrong-path entries, so the queue is cleared: head=tail, count=0. An alloc in the same cycle is also discarded.
- resolve_valid with count==0: ignored, and resolve_err is set sticky until reset.
- Simultaneous alloc + correct resolve: both occur; count unchanged. When full, alloc is dropped regardless of the resolve.
- flush_all has highest priority: clears the queue and discards the same-cycle alloc and resolve. upd_valid=0 and mispredict=0 next cycle.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- upd_valid and mispredict are single-cycle pulses and deassert unless re-triggered.

Optional Feature:
- BPQ_STATS_EN defined: adds 32-bit outputs stat_resolved and stat_mispredict.
  - Both reset to 0.
  - stat_resolved increments on each accepted resolve; stat_mispredict increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF.
- BPQ_STATS_EN undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- bp_pkg holds:
  - typedef bpq_entry_t {pred, index[PHT_DEPTH], ghr[GHR_WIDTH], alt_pc[32]};
  - default PHT_DEPTH and GHR_WIDTH localparams.
- Sub-module bpq_sat_counter: 32-bit saturating counter, instantiated twice under BPQ_STATS_EN.

Test Plan:
- Alloc 4 entries (pred=1, index 0x10..0x13) -> count=4, alloc_ready=0; a 5th alloc is dropped, count stays 4.
- Resolve the head with taken=1 (pred=1) -> next cycle upd_valid=1, upd_index=0x10, upd_taken=1, mispredict=0, count=3.
- Entry pred=1, ghr=4'b0110, alt_pc=0xBFC0_0100, resolved taken=0 -> next cycle mispredict=1, recover_pc=0xBFC0_0100, recover_ghr=4'b1100, count=0; a same-cycle alloc is discarded.
- Fill 2 entries, assert flush_all together with resolve_valid -> count=0, upd_valid=0, mispredict=0 next cycle.
- Resolve on an empty queue -> resolve_err=1 and stays 1; pulse rst=0 -> resolve_err=0, count=0, alloc_ready=1.
- Stream 10 alloc+resolve pairs at DEPTH=4 -> pointers wrap and the upd_index sequence matches alloc order; with BPQ_STATS_EN, stat_resolved=10.
